// File: rtl/clock_pkg.sv
// clock_pkg: shared hour FSM states, BCD hour constants and 12/24-hour conversions.
package clock_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, EDIT, COMMIT} state_t;
  localparam logic [7:0] H12 = 8'h12;
  localparam logic [7:0] H01 = 8'h01;
  localparam logic [7:0] H00 = 8'h00;
  typedef struct packed {
    logic       pm;
    logic [7:0] hour;
  } h12_t;
  function automatic logic [7:0] bcd2bin(input logic [7:0] h);
    return 8'(h[7:4]) * 8'd10 + 8'(h[3:0]);
  endfunction
  function automatic logic [7:0] bin2bcd(input logic [7:0] b);
    return ((b / 8'd10) << 4) | (b % 8'd10);
  endfunction
  function automatic h12_t bcd_24to12(input logic [7:0] h);
    logic [7:0] b;
    b = bcd2bin(h);
    if (h[7:4] > 4'd9 || h[3:0] > 4'd9 || b > 8'd23) return '{pm: 1'b0, hour: H12};
    if (b == 8'd0) return '{pm: 1'b0, hour: H12};
    if (b < 8'd12) return '{pm: 1'b0, hour: h};
    if (b == 8'd12) return '{pm: 1'b1, hour: H12};
    return '{pm: 1'b1, hour: bin2bcd(b - 8'd12)};
  endfunction
  function automatic logic [7:0] bcd_12to24(input logic [7:0] hour, input logic pm);
    logic [7:0] b;
    b = bcd2bin(hour);
    return bin2bcd(pm ? (b == 8'd12 ? 8'd12 : b + 8'd12) : (b == 8'd12 ? 8'd0 : b));
  endfunction
endpackage

// File: rtl/hour_set_12to24_step.sv
// bcd_hour12_step: one BCD step of a 12-hour value with 12<->1 wrap; inc+dec cancel.
module bcd_hour12_step
  import clock_pkg::*;
(
  input  logic [7:0] hour_i,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] hour_o
);
  always_comb begin
    hour_o = (inc && !dec) ? (hour_i == H12 ? H01 :
                              hour_i[3:0] == 4'd9 ? {hour_i[7:4] + 4'd1, 4'd0} : hour_i + 8'd1) :
             (dec && !inc) ? (hour_i == H01 ? H12 :
                              hour_i[3:0] == 4'd0 ? {hour_i[7:4] - 4'd1, 4'd9} : hour_i - 8'd1) :
             hour_i;
  end
endmodule

// File: rtl/hour_set_12to24.sv
// hour_set_12to24: edits the hour in 12-hour BCD and commits it back as 24-hour BCD.
module hour_set_12to24
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_ampm,
  input  logic [7:0] cur_hour,
  output logic [7:0] hour12,
  output logic       pm,
  output logic       editing,
  output logic [7:0] hour24,
  output logic       load
);
  state_t     state_q, state_d;
  logic [7:0] hour12_q, hour12_d, hour24_q, hour24_d, step_hour;
  logic       pm_q, pm_d, inc_q, dec_q, ampm_q;
  logic       edit_act, rpt_inc, rpt_dec, step_inc, step_dec;
  h12_t       cap;
  assign edit_act = state_q == EDIT && set_mode;
`ifdef AUTO_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = $clog2(RMAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep_q, rep_d, held, fire;
  always_comb begin
    held    = edit_act && (btn_inc ^ btn_dec) && ((btn_inc && inc_q) || (btn_dec && dec_q));
    fire    = held && cnt_q == (rep_q ? CW'(REPEAT_RATE - 1) : CW'(REPEAT_DELAY - 1));
    cnt_d   = (held && !fire) ? cnt_q + CW'(1) : '0;
    rep_d   = held && (rep_q || fire);
    rpt_inc = fire && btn_inc;
    rpt_dec = fire && btn_dec;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end
`else
  assign rpt_inc = 1'b0;
  assign rpt_dec = 1'b0;
`endif
  assign step_inc = (btn_inc && !inc_q) || rpt_inc;
  assign step_dec = (btn_dec && !dec_q) || rpt_dec;
  bcd_hour12_step u_step (
    .hour_i (hour12_q),
    .inc    (step_inc),
    .dec    (step_dec),
    .hour_o (step_hour)
  );
  always_comb begin
    cap      = bcd_24to12(cur_hour);
    state_d  = (state_q == IDLE && set_mode) ? CAPTURE :
               state_q == CAPTURE ? EDIT :
               (state_q == EDIT && !set_mode) ? COMMIT :
               state_q == COMMIT ? IDLE : state_q;
    hour12_d = state_q == CAPTURE ? cap.hour : edit_act ? step_hour : hour12_q;
    pm_d     = state_q == CAPTURE ? cap.pm : (edit_act && btn_ampm && !ampm_q) ? ~pm_q : pm_q;
    hour24_d = (state_q == EDIT && !set_mode) ? bcd_12to24(hour12_q, pm_q) : hour24_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hour12_q <= H12;
      pm_q     <= 1'b0;
      hour24_q <= H00;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      ampm_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hour12_q <= hour12_d;
      pm_q     <= pm_d;
      hour24_q <= hour24_d;
      inc_q    <= btn_inc;
      dec_q    <= btn_dec;
      ampm_q   <= btn_ampm;
    end
  end
  assign load    = state_q == COMMIT;
  assign editing = state_q == CAPTURE || state_q == EDIT;
  assign hour12  = hour12_q;
  assign pm      = pm_q;
  assign hour24  = hour24_q;
endmodule

// File: tb/tb_hour_set_12to24.sv
// tb_hour_set_12to24: table-driven, scoreboarded check of the 12-hour hour-set controller.
module tb_hour_set_12to24;
  logic       clk = 1'b0, rst_n = 1'b0, set_mode = 1'b0;
  logic       btn_inc = 1'b0, btn_dec = 1'b0, btn_ampm = 1'b0;
  logic [7:0] cur_hour = 8'h00;
  logic [7:0] hour12, hour24;
  logic       pm, editing, load;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic [7:0] h;
    logic       pm;
  } exp_t;
  typedef struct {
    logic       inc, dec, ampm;
    logic [7:0] h;
    logic       pm;
  } vec_t;
  exp_t sb[$];
  vec_t vecs[12];

  hour_set_12to24 #(.REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_mode (set_mode),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .btn_ampm (btn_ampm),
    .cur_hour (cur_hour),
    .hour12   (hour12),
    .pm       (pm),
    .editing  (editing),
    .hour24   (hour24),
    .load     (load)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic i, input logic d, input logic a,
                       input logic [7:0] h, input logic p, input string nm);
    exp_t e;
    btn_inc = i; btn_dec = d; btn_ampm = a;
    sb.push_back('{h: h, pm: p});
    cyc(1);
    btn_inc = 1'b0; btn_dec = 1'b0; btn_ampm = 1'b0;
    cyc(1);
    e = sb.pop_front();
    chk({nm, ".hour12"}, hour12, e.h);
    chk({nm, ".pm"}, {7'd0, pm}, {7'd0, e.pm});
  endtask

  task automatic enter(input logic [7:0] h, input logic [7:0] eh, input logic ep, input string nm);
    cur_hour = h;
    set_mode = 1'b1;
    cyc(1);
    chk({nm, ".editing"}, {7'd0, editing}, 8'd1);
    cyc(1);
    chk({nm, ".cap_hour12"}, hour12, eh);
    chk({nm, ".cap_pm"}, {7'd0, pm}, {7'd0, ep});
  endtask

  task automatic commit(input logic [7:0] e24, input logic inc_exit, input string nm);
    set_mode = 1'b0;
    btn_inc = inc_exit;
    cyc(1);
    btn_inc = 1'b0;
    chk({nm, ".load"}, {7'd0, load}, 8'd1);
    chk({nm, ".hour24"}, hour24, e24);
    cyc(1);
    chk({nm, ".load_end"}, {7'd0, load}, 8'd0);
    chk({nm, ".editing_end"}, {7'd0, editing}, 8'd0);
  endtask

  initial begin
    int k;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h12, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h01, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h12, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h12, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h12, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h10, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h09, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h10, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h09, 1'b1};

    cyc(2);
    chk("rst.hour12", hour12, 8'h12);
    chk("rst.pm", {7'd0, pm}, 8'd0);
    chk("rst.hour24", hour24, 8'h00);
    chk("rst.load", {7'd0, load}, 8'd0);
    chk("rst.editing", {7'd0, editing}, 8'd0);
    rst_n = 1'b1;
    cyc(1);

    enter(8'h00, 8'h12, 1'b0, "cap00");
    commit(8'h00, 1'b0, "cap00");

    enter(8'h15, 8'h03, 1'b1, "t2");
    for (int i = 1; i <= 7; i++) begin
      k = 3 + i;
      press(1'b1, 1'b0, 1'b0, k < 10 ? 8'(k) : 8'h10 + 8'(k - 10), 1'b1, $sformatf("t2.inc%0d", i));
    end
    commit(8'h22, 1'b1, "t2");
    cyc(4);
    chk("t2.hold24", hour24, 8'h22);

    enter(8'h11, 8'h11, 1'b0, "tbl");
    for (int i = 0; i < 12; i++)
      press(vecs[i].inc, vecs[i].dec, vecs[i].ampm, vecs[i].h, vecs[i].pm, $sformatf("tbl%0d", i));
    commit(8'h21, 1'b0, "tbl");

    enter(8'h12, 8'h12, 1'b1, "noon");
    commit(8'h12, 1'b0, "noon");
    enter(8'h23, 8'h11, 1'b1, "h23");
    commit(8'h23, 1'b0, "h23");
    enter(8'h1A, 8'h12, 1'b0, "bad1A");
    commit(8'h00, 1'b0, "bad1A");
    enter(8'h24, 8'h12, 1'b0, "bad24");
    press(1'b0, 1'b0, 1'b1, 8'h12, 1'b1, "bad24.ampm");
    commit(8'h12, 1'b0, "bad24");

    btn_inc = 1'b1;
    cyc(1);
    btn_inc = 1'b0;
    cyc(1);
    enter(8'h07, 8'h07, 1'b0, "idle_edge");

    press(1'b1, 1'b0, 1'b0, 8'h08, 1'b0, "abort.inc");
    rst_n = 1'b0;
    cyc(1);
    chk("abort.editing", {7'd0, editing}, 8'd0);
    chk("abort.hour24", hour24, 8'h00);
    chk("abort.hour12", hour12, 8'h12);
    set_mode = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort.load%0d", i), {7'd0, load}, 8'd0);
      cyc(1);
    end

`ifdef AUTO_REPEAT_EN
    enter(8'h01, 8'h01, 1'b0, "rpt");
    btn_inc = 1'b1;
    cyc(20);
    btn_inc = 1'b0;
    cyc(1);
    chk("rpt.held20", hour12, 8'h05);
    cyc(10);
    chk("rpt.stopped", hour12, 8'h05);
    commit(8'h05, 1'b0, "rpt");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
